// File: rtl/conv_operand_loader.sv
// Operand-assembly front end for ConvolutionUnit: takes a dimension header and a
// row-major byte stream, packs input matrix and kernel into flat buses, then holds them.
module conv_operand_loader (
  input  logic         clk,
  input  logic         reset,
  input  logic         abort,
  input  logic         cfg_valid,
  input  logic [2:0]   cfg_in_m,
  input  logic [2:0]   cfg_in_n,
  input  logic [1:0]   cfg_k_m,
  input  logic [1:0]   cfg_k_n,
  output logic         cfg_ready,
  input  logic         elem_valid,
  input  logic [7:0]   elem_data,
  output logic         elem_ready,
  output logic [2:0]   in_m,
  output logic [2:0]   in_n,
  output logic [1:0]   k_m,
  output logic [1:0]   k_n,
  output logic [399:0] matrices_in,
  output logic [71:0]  kernelMatrix,
  output logic         load_done,
  output logic         cfg_err,
  output logic [1:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid may
  // be held across cycles, ready depends only on the current state.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD_IN = 2'd1,
    S_LOAD_K  = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [2:0]     in_m_q, in_m_d, in_n_q, in_n_d;
  logic [1:0]     k_m_q, k_m_d, k_n_q, k_n_d;
  logic [2:0]     row_q, row_d, col_q, col_d;
  logic [199:0]   mat_q, mat_d;
  logic [71:0]    ker_q, ker_d;
  logic           cfg_err_q, cfg_err_d;

  logic           hdr_legal;
  logic [4:0]     in_idx;
  logic [3:0]     k_idx;
  logic           in_last_col, in_last_row, k_last_col, k_last_row;

  assign hdr_legal = (cfg_in_m != 3'd0) && (cfg_in_m <= 3'd5) &&
                     (cfg_in_n != 3'd0) && (cfg_in_n <= 3'd5) &&
                     (cfg_k_m != 2'd0) && (cfg_k_n != 2'd0);

  assign in_idx      = {2'b00, row_q} * 5'd5 + {2'b00, col_q};
  assign k_idx       = {2'b00, row_q[1:0]} * 4'd3 + {2'b00, col_q[1:0]};
  assign in_last_col = (col_q == in_n_q - 3'd1);
  assign in_last_row = (row_q == in_m_q - 3'd1);
  assign k_last_col  = (col_q[1:0] == k_n_q - 2'd1);
  assign k_last_row  = (row_q[1:0] == k_m_q - 2'd1);

  always_comb begin
    state_d   = state_q;
    in_m_d    = in_m_q;
    in_n_d    = in_n_q;
    k_m_d     = k_m_q;
    k_n_d     = k_n_q;
    row_d     = row_q;
    col_d     = col_q;
    mat_d     = mat_q;
    ker_d     = ker_q;
    cfg_err_d = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      in_m_d  = '0;
      in_n_d  = '0;
      k_m_d   = '0;
      k_n_d   = '0;
      row_d   = '0;
      col_d   = '0;
      mat_d   = '0;
      ker_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (cfg_valid) begin
            if (hdr_legal) begin
              state_d = S_LOAD_IN;
              in_m_d  = cfg_in_m;
              in_n_d  = cfg_in_n;
              k_m_d   = cfg_k_m;
              k_n_d   = cfg_k_n;
              row_d   = '0;
              col_d   = '0;
              mat_d   = '0;
              ker_d   = '0;
            end else begin
              // Illegal header leaves everything, including a finished load, intact.
              cfg_err_d = 1'b1;
            end
          end
        end
        S_LOAD_IN: begin
          if (elem_valid) begin
            mat_d[{in_idx, 3'b000} +: 8] = elem_data;
            if (in_last_col) begin
              col_d = '0;
              if (in_last_row) begin
                row_d   = '0;
                state_d = S_LOAD_K;
              end else begin
                row_d = row_q + 3'd1;
              end
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end
        S_LOAD_K: begin
          if (elem_valid) begin
            ker_d[{k_idx, 3'b000} +: 8] = elem_data;
            if (k_last_col) begin
              col_d = '0;
              if (k_last_row) begin
                row_d   = '0;
                state_d = S_DONE;
              end else begin
                row_d = row_q + 3'd1;
              end
            end else begin
              col_d = col_q + 3'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      in_m_q    <= '0;
      in_n_q    <= '0;
      k_m_q     <= '0;
      k_n_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      mat_q     <= '0;
      ker_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_m_q    <= in_m_d;
      in_n_q    <= in_n_d;
      k_m_q     <= k_m_d;
      k_n_q     <= k_n_d;
      row_q     <= row_d;
      col_q     <= col_d;
      mat_q     <= mat_d;
      ker_q     <= ker_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_ready    = (state_q == S_IDLE) || (state_q == S_DONE);
  assign elem_ready   = (state_q == S_LOAD_IN) || (state_q == S_LOAD_K);
  assign load_done    = (state_q == S_DONE);
  assign in_m         = in_m_q;
  assign in_n         = in_n_q;
  assign k_m          = k_m_q;
  assign k_n          = k_n_q;
  assign matrices_in  = {200'd0, mat_q};
  assign kernelMatrix = ker_q;
  assign cfg_err      = cfg_err_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/conv_operand_loader.md
# conv_operand_loader

Upstream operand-assembly stage for `ConvolutionUnit`. It accepts a dimension header and then a byte stream of matrix elements over valid/ready handshakes. It packs the elements into the flat `matrices_in` / `kernelMatrix` buses the convolution unit consumes. Once every element has been captured, it holds the assembled operands and dimensions stable and raises `load_done`, so the combinational convolution result is valid downstream.

## Interface
Parameters: none. Dimensions are fixed by the `ConvolutionUnit` bus format: input matrix up to 5x5, kernel up to 3x3, 8-bit elements.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — asynchronous, active-high; clears all state and outputs.
- `abort` in 1 — synchronous clear back to IDLE; priority over all other inputs.
- `cfg_valid` in 1 — dimension header present.
- `cfg_in_m` in 3 — input rows, legal 1..5.
- `cfg_in_n` in 3 — input cols, legal 1..5.
- `cfg_k_m` in 2 — kernel rows, legal 1..3.
- `cfg_k_n` in 2 — kernel cols, legal 1..3.
- `cfg_ready` out 1 — header can be accepted; high in IDLE and DONE.
- `elem_valid` in 1 — element byte present.
- `elem_data` in 8 — element value, unsigned.
- `elem_ready` out 1 — element can be accepted; high in LOAD_IN and LOAD_K.
- `in_m`, `in_n` out 3 — latched input dims, to `ConvolutionUnit`.
- `k_m`, `k_n` out 2 — latched kernel dims, to `ConvolutionUnit`.
- `matrices_in` out 400 — packed input matrix.
- `kernelMatrix` out 72 — packed kernel.
- `load_done` out 1 — level; operands complete and stable.
- `cfg_err` out 1 — one-cycle pulse on an illegal header.

## Operation
- **Packing.**
  - Input element (r,c) goes to `matrices_in[(r*5+c)*8 +: 8]` (matrix-0 slot).
  - Bits [399:200] are always 0.
  - Unused positions inside the 5x5 area are 0.
  - Kernel element (r,c) goes to `kernelMatrix[(r*3+c)*8 +: 8]`; unused positions are 0.
- **Stream order.** All `in_m*in_n` input elements come first, row-major. Then all `k_m*k_n` kernel elements, row-major.
- **FSM states:** IDLE, LOAD_IN, LOAD_K, DONE.
- **IDLE / DONE, legal header.** A header is accepted when `cfg_valid && cfg_ready` and all four dims are within their legal range. On acceptance:
  - latch the dims;
  - zero `matrices_in` and `kernelMatrix`;
  - set row=col=0;
  - go to LOAD_IN.
  - In DONE this restarts the loader, and prior contents are discarded.
- **IDLE / DONE, illegal header.** Any dim out of range:
  - pulse `cfg_err`;
  - state, dims, and bus contents are unchanged.
- **LOAD_IN.** Each `elem_valid && elem_ready` writes `elem_data` at (row,col).
  - Col increments; at col==in_n-1 it wraps to 0 and row increments.
  - The write at (in_m-1, in_n-1) moves to LOAD_K with row=col=0.
- **LOAD_K.** Same indexing against `k_m`/`k_n`. The write at (k_m-1, k_n-1) moves to DONE.
- **DONE.** `load_done`=1, and all outputs are held.
- **Dimension policy.** Whether the kernel exceeds the input is not checked here; `ConvolutionUnit.valid` reports that.
- **Ignored inputs.**
  - `elem_valid` in IDLE/DONE is ignored (`elem_ready`=0).
  - `cfg_valid` in LOAD_IN/LOAD_K is ignored (`cfg_ready`=0); no error is raised.
- **abort.** Next state is IDLE. Dims, buses, and counters go to 0; `load_done`=0.

## Timing
- **Reset values.** All outputs are 0 except `cfg_ready`=1 (IDLE). Reset may assert in any state, including mid-load; the partial load is lost.
- **Header to first element.** Header accepted at edge T means `elem_ready`=1 from T+1.
- **Throughput.** One element per cycle when `elem_valid` is held high. Bubbles (`elem_valid`=0) stall the indices without side effects.
- **Completion.** The last kernel element accepted at edge E means `load_done`=1 and `cfg_ready`=1 from E+1.
- **Minimum latency.** Header to `load_done` is 1 + in_m*in_n + k_m*k_n cycles.
- **Error pulse.** `cfg_err` asserts the cycle after the illegal header edge, for exactly 1 cycle. A header held illegal across several cycles pulses once per accepting edge.
- **Simultaneous events.**
  - `abort` and `cfg_valid` together: abort wins, and the header is dropped.
  - `abort` and an element beat together: the element is dropped.
- **Downstream view.** `load_done` falls in the cycle after a new legal header is accepted from DONE. Buses are zeroed in that same cycle.

## Test plan
1. **4x4 input, 2x2 kernel.**
   - Stimulus: header 4x4/2x2, elements 1..16, then four 1s, no bubbles.
   - Expected: `load_done` high 21 cycles after the header edge; `matrices_in` byte (r*5+c) = r*4+c+1.
   - Expected: the attached `ConvolutionUnit` outputs 3x3 = 14 18 22 / 30 34 38 / 46 50 54 with `valid`=1.
2. **Full size with bubbles.**
   - Stimulus: 5x5/3x3 load with `elem_valid` toggling every other cycle, values 1..25 then 1..9.
   - Expected: all 34 bytes placed correctly; bits [399:200] are 0; `load_done` 1 + 2*34 - 1 cycles after the header edge.
3. **Illegal header.**
   - Stimulus: header `in_m`=0, then `k_n`=0 (illegal headers, each a separate cycle).
   - Expected: one `cfg_err` pulse each; state stays IDLE; `elem_ready`=0; outputs remain 0.
4. **Reload from DONE.**
   - Stimulus: after scenario 1, header 1x1/1x1 with elements 7, 3.
   - Expected: `matrices_in` byte0=7 and all other bytes 0; `kernelMatrix` byte0=3.
   - Expected: `load_done` low for exactly 2 cycles, then high.
5. **abort mid-load.**
   - Stimulus: after 6 input elements of a 4x4 load, pulse `abort` coincident with element 7.
   - Expected: IDLE next cycle; buses 0; element 7 not written; a new header restarts cleanly.
6. **Asynchronous reset mid-load.**
   - Stimulus: assert `reset` between clock edges during LOAD_K.
   - Expected: outputs go to reset values immediately, without waiting for an edge; `cfg_ready`=1 after release.
